// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: datapath width, ALU operations and operand-select codes.
package riscv_pkg;

    localparam int PKG_XLEN    = 32;
    localparam int PKG_RADDR_W = 5;

    typedef logic [PKG_XLEN-1:0] xlen_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } opa_sel_e;

    typedef enum logic [1:0] {
        OPB_RS2  = 2'd0,
        OPB_IMM  = 2'd1,
        OPB_FOUR = 2'd2
    } opb_sel_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Bundle of decode-side, forwarding, flush and EX-side signals around the ID/EX operand stage.
interface alu_operand_stage_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) ();
    import riscv_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [RADDR_W-1:0] in_rs1_addr;
    logic [RADDR_W-1:0] in_rs2_addr;
    logic               in_rs1_used;
    logic               in_rs2_used;
    logic [XLEN-1:0]    in_rs1_data;
    logic [XLEN-1:0]    in_rs2_data;
    logic [XLEN-1:0]    in_imm;
    logic [XLEN-1:0]    in_pc;
    opa_sel_e           in_op_a_sel;
    opb_sel_e           in_op_b_sel;
    alu_op_e            in_alu_op;
    logic [RADDR_W-1:0] in_rd_addr;
    logic               in_rd_we;

    logic [RADDR_W-1:0] mem_rd_addr;
    logic               mem_rd_we;
    logic               mem_data_vld;
    logic [XLEN-1:0]    mem_data;
    logic [RADDR_W-1:0] wb_rd_addr;
    logic               wb_rd_we;
    logic [XLEN-1:0]    wb_data;

    logic               flush;

    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    op_a;
    logic [XLEN-1:0]    op_b;
    alu_op_e            alu_op;
    logic [XLEN-1:0]    rs2_fwd;
    logic [XLEN-1:0]    pc_q;
    logic [RADDR_W-1:0] rd_addr;
    logic               rd_we;

    modport slave (
        input  in_valid, in_rs1_addr, in_rs2_addr, in_rs1_used, in_rs2_used,
               in_rs1_data, in_rs2_data, in_imm, in_pc, in_op_a_sel, in_op_b_sel,
               in_alu_op, in_rd_addr, in_rd_we,
               mem_rd_addr, mem_rd_we, mem_data_vld, mem_data,
               wb_rd_addr, wb_rd_we, wb_data, flush, out_ready,
        output in_ready, out_valid, op_a, op_b, alu_op, rs2_fwd, pc_q, rd_addr, rd_we
    );

    modport master (
        output in_valid, in_rs1_addr, in_rs2_addr, in_rs1_used, in_rs2_used,
               in_rs1_data, in_rs2_data, in_imm, in_pc, in_op_a_sel, in_op_b_sel,
               in_alu_op, in_rd_addr, in_rd_we,
               mem_rd_addr, mem_rd_we, mem_data_vld, mem_data,
               wb_rd_addr, wb_rd_we, wb_data, flush, out_ready,
        input  in_ready, out_valid, op_a, op_b, alu_op, rs2_fwd, pc_q, rd_addr, rd_we
    );

endinterface

// File: rtl/fwd_mux.sv
// Resolves one source register against the MEM and WB result buses.
module fwd_mux #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] src_addr_i,
    input  logic [XLEN-1:0]    rf_data_i,
    input  logic [RADDR_W-1:0] mem_rd_addr_i,
    input  logic               mem_rd_we_i,
    input  logic               mem_data_vld_i,
    input  logic [XLEN-1:0]    mem_data_i,
    input  logic [RADDR_W-1:0] wb_rd_addr_i,
    input  logic               wb_rd_we_i,
    input  logic [XLEN-1:0]    wb_data_i,
    output logic [XLEN-1:0]    fwd_data_o
);

    // x0 wins outright; MEM only counts once its result is actually available
    always_comb begin
        fwd_data_o = rf_data_i;
        if (src_addr_i == {RADDR_W{1'b0}}) begin
            fwd_data_o = {XLEN{1'b0}};
        end else if (mem_rd_we_i && (mem_rd_addr_i == src_addr_i) && mem_data_vld_i) begin
            fwd_data_o = mem_data_i;
        end else if (wb_rd_we_i && (wb_rd_addr_i == src_addr_i)) begin
            fwd_data_o = wb_data_i;
        end else begin
            fwd_data_o = rf_data_i;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register: forwards sources, selects ALU operands, stalls on load-use, flushes.
module alu_operand_stage
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input logic                clk,
    input logic                rst_n,
    alu_operand_stage_if.slave bus
);

    logic [XLEN-1:0]    rs1_fwd_s;
    logic [XLEN-1:0]    rs2_fwd_s;
    logic [XLEN-1:0]    op_a_s;
    logic [XLEN-1:0]    op_b_s;
    logic               hazard_s;
    logic               advance_s;
    logic               in_ready_s;
    logic               capture_s;

    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    op_a_q, op_a_d;
    logic [XLEN-1:0]    op_b_q, op_b_d;
    alu_op_e            alu_op_q, alu_op_d;
    logic [XLEN-1:0]    rs2_fwd_q, rs2_fwd_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [RADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic               rd_we_q, rd_we_d;

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
        .src_addr_i     (bus.in_rs1_addr),
        .rf_data_i      (bus.in_rs1_data),
        .mem_rd_addr_i  (bus.mem_rd_addr),
        .mem_rd_we_i    (bus.mem_rd_we),
        .mem_data_vld_i (bus.mem_data_vld),
        .mem_data_i     (bus.mem_data),
        .wb_rd_addr_i   (bus.wb_rd_addr),
        .wb_rd_we_i     (bus.wb_rd_we),
        .wb_data_i      (bus.wb_data),
        .fwd_data_o     (rs1_fwd_s)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
        .src_addr_i     (bus.in_rs2_addr),
        .rf_data_i      (bus.in_rs2_data),
        .mem_rd_addr_i  (bus.mem_rd_addr),
        .mem_rd_we_i    (bus.mem_rd_we),
        .mem_data_vld_i (bus.mem_data_vld),
        .mem_data_i     (bus.mem_data),
        .wb_rd_addr_i   (bus.wb_rd_addr),
        .wb_rd_we_i     (bus.wb_rd_we),
        .wb_data_i      (bus.wb_data),
        .fwd_data_o     (rs2_fwd_s)
    );

    // Load-use: a used source matches a MEM-stage load whose data is not back yet
    always_comb begin
        hazard_s = 1'b0;
        if (bus.in_valid && bus.mem_rd_we && (bus.mem_rd_addr != {RADDR_W{1'b0}}) && !bus.mem_data_vld) begin
            hazard_s = (bus.in_rs1_used && (bus.in_rs1_addr == bus.mem_rd_addr)) ||
                       (bus.in_rs2_used && (bus.in_rs2_addr == bus.mem_rd_addr));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Operand A/B selection ahead of the pipeline register
    always_comb begin
        op_a_s = {XLEN{1'b0}};
        op_b_s = {XLEN{1'b0}};
        case (bus.in_op_a_sel)
            OPA_RS1:  op_a_s = rs1_fwd_s;
            OPA_PC:   op_a_s = bus.in_pc;
            OPA_ZERO: op_a_s = {XLEN{1'b0}};
            default:  op_a_s = {XLEN{1'b0}};
        endcase
        case (bus.in_op_b_sel)
            OPB_RS2:  op_b_s = rs2_fwd_s;
            OPB_IMM:  op_b_s = bus.in_imm;
            OPB_FOUR: op_b_s = {{(XLEN-3){1'b0}}, 3'd4};
            default:  op_b_s = {XLEN{1'b0}};
        endcase
    end

    assign advance_s  = !out_valid_q || bus.out_ready;
    assign in_ready_s = bus.flush || (advance_s && !hazard_s);
    assign capture_s  = bus.in_valid && in_ready_s && !bus.flush;

    // Next state: flush beats capture, capture beats bubble, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        alu_op_d    = alu_op_q;
        rs2_fwd_d   = rs2_fwd_q;
        pc_d        = pc_q;
        rd_addr_d   = rd_addr_q;
        rd_we_d     = rd_we_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (capture_s) begin
            out_valid_d = 1'b1;
            op_a_d      = op_a_s;
            op_b_d      = op_b_s;
            alu_op_d    = bus.in_alu_op;
            rs2_fwd_d   = rs2_fwd_s;
            pc_d        = bus.in_pc;
            rd_addr_d   = bus.in_rd_addr;
            rd_we_d     = bus.in_rd_we;
        end else if (advance_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op_a_q      <= {XLEN{1'b0}};
            op_b_q      <= {XLEN{1'b0}};
            alu_op_q    <= ALU_ADD;
            rs2_fwd_q   <= {XLEN{1'b0}};
            pc_q        <= {XLEN{1'b0}};
            rd_addr_q   <= {RADDR_W{1'b0}};
            rd_we_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            alu_op_q    <= alu_op_d;
            rs2_fwd_q   <= rs2_fwd_d;
            pc_q        <= pc_d;
            rd_addr_q   <= rd_addr_d;
            rd_we_q     <= rd_we_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rs2_fwd   = rs2_fwd_q;
    assign bus.pc_q      = pc_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_we     = rd_we_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, multi-cycle corner sequences, random vs. reference model.
module tb_alu_operand_stage;
    import riscv_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_operand_stage_if #(.XLEN(32), .RADDR_W(5)) bus ();

    alu_operand_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: what EX should currently be holding
    logic        m_valid;
    logic [31:0] m_op_a, m_op_b, m_rs2, m_pc;
    alu_op_e     m_alu;
    logic [4:0]  m_rd;
    logic        m_we;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] rf1, rf2, imm, pc;
        opa_sel_e    asel;
        opb_sel_e    bsel;
        alu_op_e     op;
        logic [4:0]  mrd;
        logic        mwe, mvld;
        logic [31:0] mdata;
        logic [4:0]  wrd;
        logic        wwe;
        logic [31:0] wdata;
        logic [31:0] exp_a, exp_b, exp_rs2;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        if (bus.mem_rd_we && bus.mem_rd_addr == a && bus.mem_data_vld) return bus.mem_data;
        if (bus.wb_rd_we && bus.wb_rd_addr == a) return bus.wb_data;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        logic hit;
        hit = (bus.in_rs1_used && bus.in_rs1_addr == bus.mem_rd_addr) ||
              (bus.in_rs2_used && bus.in_rs2_addr == bus.mem_rd_addr);
        return bus.in_valid && bus.mem_rd_we && bus.mem_rd_addr != 5'd0 && !bus.mem_data_vld && hit;
    endfunction

    function automatic logic ref_ready();
        return bus.flush || ((!m_valid || bus.out_ready) && !ref_hazard());
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_op_a = 32'd0; m_op_b = 32'd0; m_rs2 = 32'd0;
        m_pc = 32'd0; m_alu = ALU_ADD; m_rd = 5'd0; m_we = 1'b0;
    endtask

    task automatic set_idle();
        bus.in_valid = 1'b0; bus.in_rs1_addr = 5'd0; bus.in_rs2_addr = 5'd0;
        bus.in_rs1_used = 1'b0; bus.in_rs2_used = 1'b0;
        bus.in_rs1_data = 32'd0; bus.in_rs2_data = 32'd0; bus.in_imm = 32'd0; bus.in_pc = 32'd0;
        bus.in_op_a_sel = OPA_RS1; bus.in_op_b_sel = OPB_RS2; bus.in_alu_op = ALU_ADD;
        bus.in_rd_addr = 5'd0; bus.in_rd_we = 1'b0;
        bus.mem_rd_addr = 5'd0; bus.mem_rd_we = 1'b0; bus.mem_data_vld = 1'b0; bus.mem_data = 32'd0;
        bus.wb_rd_addr = 5'd0; bus.wb_rd_we = 1'b0; bus.wb_data = 32'd0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
    endtask

    // One clock: check in_ready against the model, step the model, then compare EX outputs
    task automatic tick();
        logic        take, nv;
        logic [31:0] na, nb, f1, f2;
        #1;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, ref_ready()});
        f1 = ref_fwd(bus.in_rs1_addr, bus.in_rs1_data);
        f2 = ref_fwd(bus.in_rs2_addr, bus.in_rs2_data);
        na = (bus.in_op_a_sel == OPA_RS1) ? f1 : (bus.in_op_a_sel == OPA_PC) ? bus.in_pc : 32'd0;
        nb = (bus.in_op_b_sel == OPB_RS2) ? f2 : (bus.in_op_b_sel == OPB_IMM) ? bus.in_imm : 32'd4;
        take = bus.in_valid && ref_ready() && !bus.flush;
        nv = bus.flush ? 1'b0 : take ? 1'b1 : (!m_valid || bus.out_ready) ? 1'b0 : m_valid;
        if (take) begin
            m_op_a = na; m_op_b = nb; m_rs2 = f2; m_pc = bus.in_pc;
            m_alu = bus.in_alu_op; m_rd = bus.in_rd_addr; m_we = bus.in_rd_we;
        end
        @(posedge clk);
        #1;
        m_valid = nv;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("op_a", bus.op_a, m_op_a);
            chk("op_b", bus.op_b, m_op_b);
            chk("rs2_fwd", bus.rs2_fwd, m_rs2);
            chk("pc_q", bus.pc_q, m_pc);
            chk("alu_op", 32'(bus.alu_op), 32'(m_alu));
            chk("rd_addr", 32'(bus.rd_addr), 32'(m_rd));
            chk("rd_we", {31'd0, bus.rd_we}, {31'd0, m_we});
        end
    endtask

    task automatic apply_vec(input vec_t v);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.flush = 1'b0;
        bus.in_rs1_addr = v.rs1; bus.in_rs2_addr = v.rs2;
        bus.in_rs1_used = 1'b1; bus.in_rs2_used = 1'b1;
        bus.in_rs1_data = v.rf1; bus.in_rs2_data = v.rf2;
        bus.in_imm = v.imm; bus.in_pc = v.pc;
        bus.in_op_a_sel = v.asel; bus.in_op_b_sel = v.bsel; bus.in_alu_op = v.op;
        bus.in_rd_addr = 5'd10; bus.in_rd_we = 1'b1;
        bus.mem_rd_addr = v.mrd; bus.mem_rd_we = v.mwe; bus.mem_data_vld = v.mvld; bus.mem_data = v.mdata;
        bus.wb_rd_addr = v.wrd; bus.wb_rd_we = v.wwe; bus.wb_data = v.wdata;
    endtask

    function automatic vec_t blank_vec();
        vec_t v;
        v.rs1 = 5'd0; v.rs2 = 5'd0; v.rf1 = 32'd0; v.rf2 = 32'd0; v.imm = 32'd0; v.pc = 32'd0;
        v.asel = OPA_RS1; v.bsel = OPB_RS2; v.op = ALU_ADD;
        v.mrd = 5'd0; v.mwe = 1'b0; v.mvld = 1'b1; v.mdata = 32'd0;
        v.wrd = 5'd0; v.wwe = 1'b0; v.wdata = 32'd0;
        v.exp_a = 32'd0; v.exp_b = 32'd0; v.exp_rs2 = 32'd0;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        checks = 0;
        failures = 0;

        // Basic ADD, no forwarding
        v = blank_vec(); v.rs1 = 5'd1; v.rf1 = 32'd5; v.rs2 = 5'd2; v.rf2 = 32'd7;
        v.exp_a = 32'd5; v.exp_b = 32'd7; v.exp_rs2 = 32'd7; vecs.push_back(v);
        // MEM beats WB beats regfile
        v = blank_vec(); v.rs1 = 5'd3; v.rf1 = 32'h33; v.rs2 = 5'd5; v.rf2 = 32'h55;
        v.mrd = 5'd3; v.mwe = 1'b1; v.mdata = 32'h11; v.wrd = 5'd3; v.wwe = 1'b1; v.wdata = 32'h22;
        v.exp_a = 32'h11; v.exp_b = 32'h55; v.exp_rs2 = 32'h55; vecs.push_back(v);
        v.mwe = 1'b0; v.exp_a = 32'h22; vecs.push_back(v);
        // x0 never forwarded
        v = blank_vec(); v.rf1 = 32'h33; v.rf2 = 32'h44; v.op = ALU_OR;
        v.mrd = 5'd0; v.mwe = 1'b1; v.mdata = 32'h11; v.wrd = 5'd0; v.wwe = 1'b1; v.wdata = 32'h22;
        v.exp_a = 32'd0; v.exp_b = 32'd0; v.exp_rs2 = 32'd0; vecs.push_back(v);
        // ZERO/IMM selection; WB forwards rs2 into store data; non-matching pending load
        v = blank_vec(); v.rs1 = 5'd1; v.rf1 = 32'h1234; v.rs2 = 5'd7; v.rf2 = 32'h77;
        v.asel = OPA_ZERO; v.bsel = OPB_IMM; v.imm = 32'hFFFF_FFF0; v.op = ALU_SLT;
        v.mrd = 5'd6; v.mwe = 1'b1; v.mvld = 1'b0; v.wrd = 5'd7; v.wwe = 1'b1; v.wdata = 32'hABCD;
        v.exp_a = 32'd0; v.exp_b = 32'hFFFF_FFF0; v.exp_rs2 = 32'hABCD; vecs.push_back(v);
        // PC + 4
        v = blank_vec(); v.rs2 = 5'd2; v.rf2 = 32'd7; v.pc = 32'h200;
        v.asel = OPA_PC; v.bsel = OPB_FOUR;
        v.exp_a = 32'h200; v.exp_b = 32'd4; v.exp_rs2 = 32'd7; vecs.push_back(v);
        // rs1 from MEM, rs2 from WB
        v = blank_vec(); v.rs1 = 5'd8; v.rf1 = 32'd1; v.rs2 = 5'd9; v.rf2 = 32'd3; v.op = ALU_SUB;
        v.mrd = 5'd8; v.mwe = 1'b1; v.mdata = 32'h77; v.wrd = 5'd9; v.wwe = 1'b1; v.wdata = 32'h99;
        v.exp_a = 32'h77; v.exp_b = 32'h99; v.exp_rs2 = 32'h99; vecs.push_back(v);

        // Reset values
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_op_a", bus.op_a, 32'd0);
        chk("rst_op_b", bus.op_b, 32'd0);
        chk("rst_rs2_fwd", bus.rs2_fwd, 32'd0);
        chk("rst_pc_q", bus.pc_q, 32'd0);
        chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("rst_rd_we", {31'd0, bus.rd_we}, 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i]);
            tick();
            chk($sformatf("vec%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("vec%0d_op_a", i), bus.op_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_op_b", i), bus.op_b, vecs[i].exp_b);
            chk($sformatf("vec%0d_rs2_fwd", i), bus.rs2_fwd, vecs[i].exp_rs2);
            chk($sformatf("vec%0d_alu_op", i), 32'(bus.alu_op), 32'(vecs[i].op));
        end

        // Load-use stall, then release when load data arrives
        set_idle();
        bus.in_valid = 1'b1; bus.in_rs1_addr = 5'd1; bus.in_rs1_data = 32'd5; bus.in_rs1_used = 1'b1;
        bus.in_rs2_addr = 5'd4; bus.in_rs2_data = 32'hDEAD; bus.in_rs2_used = 1'b1;
        bus.mem_rd_addr = 5'd4; bus.mem_rd_we = 1'b1; bus.mem_data_vld = 1'b0;
        #1;
        chk("lu_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        chk("lu_bubble", {31'd0, bus.out_valid}, 32'd0);
        bus.mem_data_vld = 1'b1; bus.mem_data = 32'h9;
        tick();
        chk("lu_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("lu_op_b", bus.op_b, 32'h9);
        chk("lu_rs2_fwd", bus.rs2_fwd, 32'h9);

        // Back-pressure: hold 3 cycles, then accept-and-capture on one edge
        set_idle();
        bus.in_valid = 1'b1; bus.in_rs1_addr = 5'd1; bus.in_rs1_data = 32'h10;
        bus.in_op_b_sel = OPB_IMM; bus.in_imm = 32'h20; bus.in_pc = 32'h40;
        tick();
        bus.out_ready = 1'b0; bus.in_rs1_data = 32'h30; bus.in_imm = 32'h40; bus.in_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_op_a", bus.op_a, 32'h10);
            chk("bp_op_b", bus.op_b, 32'h20);
            chk("bp_pc_q", bus.pc_q, 32'h40);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_next_op_a", bus.op_a, 32'h30);
        chk("bp_next_pc_q", bus.pc_q, 32'h80);

        // Flush while held with an incoming instruction
        bus.out_ready = 1'b0; bus.flush = 1'b1; bus.in_pc = 32'hC0;
        #1;
        chk("fl_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("fl_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        chk("fl_dropped", {31'd0, bus.out_valid}, 32'd0);
        // Flush during a load-use hazard
        bus.in_valid = 1'b1; bus.in_pc = 32'hD0;
        tick();
        bus.out_ready = 1'b0; bus.in_rs1_addr = 5'd6; bus.in_rs1_used = 1'b1;
        bus.mem_rd_addr = 5'd6; bus.mem_rd_we = 1'b1; bus.mem_data_vld = 1'b0; bus.flush = 1'b1;
        tick();
        chk("flhz_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset while holding a payload
        set_idle();
        bus.in_valid = 1'b1; bus.in_alu_op = ALU_XOR; bus.in_rd_addr = 5'd9; bus.in_rd_we = 1'b1;
        tick();
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rsth_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rsth_rd_we", {31'd0, bus.rd_we}, 32'd0);
        chk("rsth_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
        #2;
        rst_n = 1'b1;
        set_idle();
        bus.in_valid = 1'b1; bus.in_op_a_sel = OPA_PC; bus.in_op_b_sel = OPB_FOUR; bus.in_pc = 32'h100;
        tick();
        chk("rsth_op_a", bus.op_a, 32'h100);
        chk("rsth_op_b", bus.op_b, 32'd4);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bus.in_valid     = ($urandom_range(0, 3) != 0);
            bus.in_rs1_addr  = 5'($urandom_range(0, 3));
            bus.in_rs2_addr  = 5'($urandom_range(0, 3));
            bus.in_rs1_used  = 1'($urandom_range(0, 1));
            bus.in_rs2_used  = 1'($urandom_range(0, 1));
            bus.in_rs1_data  = $urandom;
            bus.in_rs2_data  = $urandom;
            bus.in_imm       = $urandom;
            bus.in_pc        = $urandom;
            bus.in_op_a_sel  = opa_sel_e'($urandom_range(0, 2));
            bus.in_op_b_sel  = opb_sel_e'($urandom_range(0, 2));
            bus.in_alu_op    = alu_op_e'($urandom_range(0, 9));
            bus.in_rd_addr   = 5'($urandom_range(0, 31));
            bus.in_rd_we     = 1'($urandom_range(0, 1));
            bus.mem_rd_addr  = 5'($urandom_range(0, 3));
            bus.mem_rd_we    = 1'($urandom_range(0, 1));
            bus.mem_data_vld = ($urandom_range(0, 2) != 0);
            bus.mem_data     = $urandom;
            bus.wb_rd_addr   = 5'($urandom_range(0, 3));
            bus.wb_rd_we     = 1'($urandom_range(0, 1));
            bus.wb_data      = $urandom;
            bus.flush        = ($urandom_range(0, 15) == 0);
            bus.out_ready    = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage that sits directly upstream of the ALU.
- Accepts decoded instructions from decode over a valid/ready handshake.
- Resolves rs1/rs2 against the MEM and WB forwarding paths and selects the A/B operands.
- Registers op_a, op_b and alu_op for the combinational ALU in EX; detects load-use hazards and inserts bubbles; supports pipeline flush.

Parameters:
- XLEN, 32, datapath width; must equal width of riscv_pkg::xlen_t.
- RADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode holds an instruction
- in_ready  out  1  stage accepts this cycle
- in_rs1_addr, in_rs2_addr  in  RADDR_W  source register indices
- in_rs1_used, in_rs2_used  in  1  instruction reads rs1/rs2
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_pc  in  XLEN  instruction PC
- in_op_a_sel  in  opa_sel_e  OPA_RS1/OPA_PC/OPA_ZERO
- in_op_b_sel  in  opb_sel_e  OPB_RS2/OPB_IMM/OPB_FOUR
- in_alu_op  in  alu_op_e  ALU operation
- in_rd_addr  in  RADDR_W  destination index
- in_rd_we  in  1  instruction writes rd
- mem_rd_addr  in  RADDR_W  MEM-stage destination
- mem_rd_we  in  1  MEM-stage writes rd
- mem_data_vld  in  1  MEM result available (0 for load in flight)
- mem_data  in  XLEN  MEM-stage result
- wb_rd_addr  in  RADDR_W  WB destination
- wb_rd_we  in  1  WB writes rd
- wb_data  in  XLEN  WB result
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  EX payload valid
- out_ready  in  1  EX accepts payload
- op_a, op_b  out  XLEN  ALU operands
- alu_op  out  alu_op_e  ALU operation
- rs2_fwd  out  XLEN  forwarded rs2 value (store data, branch compare)
- pc_q  out  XLEN  registered PC
- rd_addr  out  RADDR_W  registered destination
- rd_we  out  1  registered write enable

Behaviour:
- Reset (async, rst_n low): out_valid=0; op_a, op_b, rs2_fwd, pc_q=0; rd_addr=0; rd_we=0; alu_op=ALU_ADD. Applies mid-operation; held instruction is lost.
- Forwarding, per source s in {rs1, rs2}, priority order:
  - s==0 → 0.
  - mem_rd_we & mem_rd_addr==s & mem_data_vld → mem_data.
  - wb_rd_we & wb_rd_addr==s → wb_data.
  - otherwise regfile data.
- x0 is never forwarded.
- hazard = in_valid & mem_rd_we & mem_rd_addr!=0 & ~mem_data_vld & ((in_rs1_used & in_rs1_addr==mem_rd_addr) | (in_rs2_used & in_rs2_addr==mem_rd_addr)).
- Operand A: OPA_RS1 → fwd rs1; OPA_PC → in_pc; OPA_ZERO → 0.
- Operand B: OPB_RS2 → fwd rs2; OPB_IMM → in_imm; OPB_FOUR → 4.
- Operand selection is done before the register, so the ALU sees registered operands.
- in_ready = flush | ((~out_valid | out_ready) & ~hazard). Purely combinational; no dependency on in_valid except through hazard.
- Capture: in_valid & in_ready & ~flush → payload loaded and out_valid=1 on the next edge. Latency is one cycle.
- Advance without capture: (~out_valid | out_ready) with no capture (empty input or hazard) → out_valid=0 on the next edge. This is the bubble; payload registers may hold stale values.
- Hold: out_valid & ~out_ready → all payload and out_valid frozen. No re-forwarding while held, because the older pipeline stages are stalled too.
- Flush: synchronous. out_valid=0 on the next edge regardless of out_ready/in_valid. The incoming instruction is consumed (in_ready=1) and dropped. Flush overrides hazard and capture.
- Handshake rules:
  - out_valid never drops without out_ready, except on flush or reset.
  - Payload is stable while out_valid & ~out_ready.
- Simultaneous accept-and-capture: out_valid & out_ready & in_valid & ~hazard → new payload replaces old on the same edge. Full throughput is one instruction per cycle.
- Widths: all arithmetic is XLEN; the constant 4 is zero-extended.

Decomposition:
- riscv_pkg gains opa_sel_e and opb_sel_e enums; it already provides xlen_t and alu_op_e.
- One sub-module, fwd_mux: purely combinational. Takes a source index, regfile data and both forwarding ports; returns the forwarded value. Instantiated twice (rs1, rs2).
- Hazard logic and the pipeline register stay in alu_operand_stage.

Test Plan:
- Basic flow: ADD with rs1=x1 (regfile 5), rs2=x2 (regfile 7), no forwarding, out_ready=1 → next cycle out_valid=1, op_a=5, op_b=7, alu_op=ALU_ADD.
- Forward priority: rs1=x3, mem_rd=x3 data 0x11 vld=1, wb_rd=x3 data 0x22, regfile 0x33 → op_a=0x11. Drop mem_rd_we → op_a=0x22. Repeat with rs1=x0 and all matching → op_a=0.
- Load-use: mem_rd=x4 we=1 vld=0, in rs2=x4 used → in_ready=0, out_valid=0 next cycle. Then mem_data_vld=1, data 0x9 → capture, op_b=0x9, rs2_fwd=0x9.
- Back-pressure: out_ready=0 for 3 cycles with new in_valid → in_ready=0, op_a/op_b/pc_q unchanged. Release → held payload consumed and next instruction captured on the same edge.
- Flush: out_valid=1, out_ready=0, in_valid=1, flush=1 → in_ready=1, out_valid=0 next cycle, incoming not delivered. Flush during a hazard also clears out_valid.
- Reset mid-hold: rst_n low while out_valid=1 → out_valid, rd_we=0 and alu_op=ALU_ADD immediately. First capture after release works normally (OPA_PC, OPB_FOUR, pc 0x100 → op_a=0x100, op_b=4).
